// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (LSU and instruction fetch) in front of one req/gnt/rvalid memory port.
// An in-order owner FIFO routes each response back to the requester that issued it.
module mem_port_arbiter #(
    parameter int XLEN            = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int RR_MODE         = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            lsu_req_i,
    input  logic [XLEN-1:0] lsu_addr_i,
    input  logic            lsu_we_i,
    input  logic [3:0]      lsu_be_i,
    input  logic [XLEN-1:0] lsu_wdata_i,
    output logic            lsu_gnt_o,
    output logic            lsu_rvalid_o,
    output logic [XLEN-1:0] lsu_rdata_o,
    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_addr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [XLEN-1:0] if_rdata_o,
    output logic            data_clk,
    output logic            data_req_o,
    output logic [XLEN-1:0] data_addr_o,
    output logic            data_we_o,
    output logic [3:0]      data_be_o,
    output logic [XLEN-1:0] data_wdata_o,
    input  logic [XLEN-1:0] data_rdata_i,
    input  logic            data_rvalid_i,
    input  logic            data_gnt_i,
    output logic            idle_o,
    output logic [3:0]      outstanding_o,
    output logic            err_o
);

    localparam logic       OWNER_L = 1'b0;
    localparam logic       OWNER_F = 1'b1;
    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

    // Owner FIFO as a shift register: bit 0 is the head, occupancy in count_r.
    logic [MAX_OUTSTANDING-1:0] owners_r;
    logic [MAX_OUTSTANDING-1:0] owners_next_s;
    logic [3:0]                 count_r;
    logic [3:0]                 count_next_s;
    logic [3:0]                 count_after_pop_s;
    logic                       rr_last_r;
    logic                       hold_valid_r;
    logic                       hold_owner_r;
    logic                       err_r;

    logic can_issue_s;
    logic winner_s;
    logic req_s;
    logic accept_s;
    logic pop_s;
    logic orphan_s;

    assign data_clk     = clk;
    assign can_issue_s  = (count_r < MAX_CNT) || (data_rvalid_i && (count_r == MAX_CNT));
    assign req_s        = !reset && can_issue_s && (lsu_req_i || if_req_i);
    assign accept_s     = req_s && data_gnt_i;
    assign pop_s        = !reset && data_rvalid_i && (count_r != 4'd0);
    assign orphan_s     = data_rvalid_i && (count_r == 4'd0);

    // Winner selection; an ungranted winner keeps the port while it still requests.
    always_comb begin
        winner_s = OWNER_L;
        if (hold_valid_r && (hold_owner_r == OWNER_L) && lsu_req_i) begin
            winner_s = OWNER_L;
        end else if (hold_valid_r && (hold_owner_r == OWNER_F) && if_req_i) begin
            winner_s = OWNER_F;
        end else if (lsu_req_i && if_req_i) begin
            winner_s = ((RR_MODE != 0) && (rr_last_r == OWNER_L)) ? OWNER_F : OWNER_L;
        end else if (if_req_i) begin
            winner_s = OWNER_F;
        end else begin
            winner_s = OWNER_L;
        end
    end

    // Request-path mux toward memory; fetch is always a full-word read.
    always_comb begin
        data_req_o   = req_s;
        data_addr_o  = '0;
        data_we_o    = 1'b0;
        data_be_o    = 4'b0000;
        data_wdata_o = '0;
        case ({req_s, winner_s})
            {1'b1, OWNER_L}: begin
                data_addr_o  = lsu_addr_i;
                data_we_o    = lsu_we_i;
                data_be_o    = lsu_be_i;
                data_wdata_o = lsu_wdata_i;
            end
            {1'b1, OWNER_F}: begin
                data_addr_o  = if_addr_i;
                data_we_o    = 1'b0;
                data_be_o    = 4'b1111;
                data_wdata_o = '0;
            end
            default: begin
                data_addr_o  = '0;
                data_we_o    = 1'b0;
                data_be_o    = 4'b0000;
                data_wdata_o = '0;
            end
        endcase
    end

    assign lsu_gnt_o     = accept_s && (winner_s == OWNER_L);
    assign if_gnt_o      = accept_s && (winner_s == OWNER_F);
    assign lsu_rvalid_o  = pop_s && (owners_r[0] == OWNER_L);
    assign if_rvalid_o   = pop_s && (owners_r[0] == OWNER_F);
    assign lsu_rdata_o   = data_rdata_i;
    assign if_rdata_o    = data_rdata_i;
    assign idle_o        = reset || (count_r == 4'd0);
    assign outstanding_o = reset ? 4'd0 : count_r;
    assign err_o         = err_r;

    // Owner FIFO next state: pop first, then push at the post-pop tail.
    always_comb begin
        count_after_pop_s = count_r - {3'b000, pop_s};
        if (pop_s) begin
            owners_next_s = owners_r >> 1;
        end else begin
            owners_next_s = owners_r;
        end
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            owners_next_s[i] = (accept_s && (count_after_pop_s == 4'(i))) ? winner_s
                                                                            : owners_next_s[i];
        end
        count_next_s = count_after_pop_s + {3'b000, accept_s};
    end

    // State registers: FIFO, round-robin history, winner hold and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            owners_r     <= '0;
            count_r      <= 4'd0;
            rr_last_r    <= OWNER_F;
            hold_valid_r <= 1'b0;
            hold_owner_r <= OWNER_L;
            err_r        <= 1'b0;
        end else begin
            owners_r     <= owners_next_s;
            count_r      <= count_next_s;
            rr_last_r    <= accept_s ? winner_s : rr_last_r;
            hold_valid_r <= req_s && !data_gnt_i;
            hold_owner_r <= winner_s;
            err_r        <= err_r || orphan_s;
        end
    end

endmodule
